// File: rtl/procb_state_ctrl_pkg.sv
// Shared types and field layout for the procb save/restore controller.
// Save word, MSB first: total_bytes[9:0], rem_cnt[6:0], pad_pending, fin.
package procb_state_ctrl_pkg;

    localparam int PROCB_SAVE_MSB   = 18;
    localparam int PROCB_TOTAL_LSB  = 9;
    localparam int PROCB_REMCNT_LSB = 2;
    localparam int PROCB_PAD_BIT    = 1;
    localparam int PROCB_FIN_BIT    = 0;

    typedef logic [PROCB_SAVE_MSB:0] procb_save_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_OFFER = 3'd2,
        ST_RUN   = 3'd3,
        ST_SAVE  = 3'd4
    } procb_st_t;

    function automatic logic [9:0] total_of(input procb_save_t w);
        return w[PROCB_SAVE_MSB:PROCB_TOTAL_LSB];
    endfunction

endpackage

// File: rtl/procb_state_ctrl_valid_bits.sv
// Per-thread "saved record valid" flags.
// Either clear port beats a same-cycle set on the same thread.
module procb_valid_bits #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_a_en,
    input  logic [IW-1:0] clr_a_idx,
    input  logic          clr_b_en,
    input  logic [IW-1:0] clr_b_idx,
    output logic [N-1:0]  valid
);

    // Flag update: clear has priority over set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((clr_a_en && clr_a_idx == IW'(i)) ||
                    (clr_b_en && clr_b_idx == IW'(i))) begin
                    valid[i] <= 1'b0;
                end else if (set_en && set_idx == IW'(i)) begin
                    valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/procb_state_ctrl.sv
// Save/restore controller for the procb engine.
// Loads a thread's saved word into the engine and writes it back.
module procb_state_ctrl
    import procb_state_ctrl_pkg::*;
#(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_THREADS_MSB:0]  start_thread_num,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [N_THREADS_MSB:0]  clr_thread_num,
    input  logic                    clr_en,
    output logic [N_THREADS_MSB:0]  eng_thread_num,
    output logic [PROCB_SAVE_MSB:0] eng_state,
    output logic                    eng_state_valid,
    input  logic                    eng_state_ready,
    input  logic                    upd_valid,
    input  logic [PROCB_SAVE_MSB:0] upd_state,
    input  logic                    upd_finished,
    output logic                    upd_ready,
    output logic [N_THREADS_MSB:0]  mem_wr_thread_num,
    output logic                    mem_wr_en,
    output logic [PROCB_SAVE_MSB:0] mem_din,
    output logic [N_THREADS_MSB:0]  mem_rd_thread_num,
    input  logic [PROCB_SAVE_MSB:0] mem_dout,
    output logic                    err
);

    localparam int IW = N_THREADS_MSB + 1;

    procb_st_t            st;
    logic [IW-1:0]        cur_thr;
    logic [N_THREADS-1:0] valid;
    logic                 start_bad;
    logic                 clr_hits_cur;
    logic                 load_valid;
    logic                 fin_clr;
    logic                 save_set;

    assign start_bad    = 32'(start_thread_num) >= N_THREADS;
    assign clr_hits_cur = clr_en && (clr_thread_num == cur_thr);
    assign load_valid   = valid[cur_thr] && !clr_hits_cur;
    assign fin_clr      = (st == ST_RUN) && upd_valid && upd_finished;
    assign save_set     = (st == ST_SAVE);

    assign start_ready       = (st == ST_IDLE) && !RST;
    assign eng_thread_num    = cur_thr;
    assign mem_rd_thread_num = cur_thr;

    procb_valid_bits #(
        .N  (N_THREADS),
        .IW (IW)
    ) u_valid (
        .CLK       (CLK),
        .RST       (RST),
        .set_en    (save_set),
        .set_idx   (cur_thr),
        .clr_a_en  (clr_en),
        .clr_a_idx (clr_thread_num),
        .clr_b_en  (fin_clr),
        .clr_b_idx (cur_thr),
        .valid     (valid)
    );

    // Thread sequencing FSM with registered engine/RAM outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st                <= ST_IDLE;
            cur_thr           <= '0;
            eng_state         <= '0;
            eng_state_valid   <= 1'b0;
            upd_ready         <= 1'b0;
            mem_wr_en         <= 1'b0;
            mem_wr_thread_num <= '0;
            mem_din           <= '0;
            err               <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            if (upd_valid && st != ST_RUN) begin
                err <= 1'b1;
            end
            if (eng_state_ready && st != ST_OFFER) begin
                err <= 1'b1;
            end
            if (start_valid && start_bad) begin
                err <= 1'b1;
            end
            unique case (st)
                ST_IDLE: begin
                    if (start_valid && !start_bad) begin
                        cur_thr <= start_thread_num;
                        st      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    eng_state       <= load_valid ? mem_dout : '0;
                    eng_state_valid <= 1'b1;
                    st              <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (eng_state_ready) begin
                        eng_state_valid <= 1'b0;
                        upd_ready       <= 1'b1;
                        st              <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (upd_valid) begin
                        upd_ready <= 1'b0;
                        if (total_of(upd_state) < total_of(eng_state)) begin
                            err <= 1'b1;
                        end
                        if (upd_finished) begin
                            st <= ST_IDLE;
                        end else begin
                            mem_wr_en         <= 1'b1;
                            mem_wr_thread_num <= cur_thr;
                            mem_din           <= upd_state;
                            st                <= ST_SAVE;
                        end
                    end
                end
                ST_SAVE: begin
                    st <= ST_IDLE;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_procb_state_ctrl.sv
// Bench for procb_state_ctrl: directed table, corner sequences,
// and randomized transactions against a thread-level model.
module tb_procb_state_ctrl;

    logic        CLK;
    logic        RST;
    logic [3:0]  start_thread_num;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  clr_thread_num;
    logic        clr_en;
    logic [3:0]  eng_thread_num;
    logic [18:0] eng_state;
    logic        eng_state_valid;
    logic        eng_state_ready;
    logic        upd_valid;
    logic [18:0] upd_state;
    logic        upd_finished;
    logic        upd_ready;
    logic [3:0]  mem_wr_thread_num;
    logic        mem_wr_en;
    logic [18:0] mem_din;
    logic [3:0]  mem_rd_thread_num;
    logic [18:0] mem_dout;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [18:0] ram [16];

    procb_state_ctrl dut (
        .CLK               (CLK),
        .RST               (RST),
        .start_thread_num  (start_thread_num),
        .start_valid       (start_valid),
        .start_ready       (start_ready),
        .clr_thread_num    (clr_thread_num),
        .clr_en            (clr_en),
        .eng_thread_num    (eng_thread_num),
        .eng_state         (eng_state),
        .eng_state_valid   (eng_state_valid),
        .eng_state_ready   (eng_state_ready),
        .upd_valid         (upd_valid),
        .upd_state         (upd_state),
        .upd_finished      (upd_finished),
        .upd_ready         (upd_ready),
        .mem_wr_thread_num (mem_wr_thread_num),
        .mem_wr_en         (mem_wr_en),
        .mem_din           (mem_din),
        .mem_rd_thread_num (mem_rd_thread_num),
        .mem_dout          (mem_dout),
        .err               (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Saved-state RAM: synchronous write, asynchronous read.
    always @(posedge CLK) begin
        if (mem_wr_en === 1'b1) begin
            ram[mem_wr_thread_num] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign mem_dout = ram[mem_rd_thread_num];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] W(int t, int r, int p, int f);
        logic [9:0] tt;
        logic [6:0] rr;
        logic       pp;
        logic       ff;
        tt = 10'(t);
        rr = 7'(r);
        pp = 1'(p);
        ff = 1'(f);
        return {tt, rr, pp, ff};
    endfunction

    // One full schedule/load/offer/run/(save) pass for a thread.
    task automatic txn(input logic [3:0] thr, input logic [18:0] upd,
                       input logic fin, input logic cl, input logic cs,
                       input logic [18:0] exp, input int rwait,
                       input logic rc_en, input logic [3:0] rc_thr);
        int w0;
        w0 = wr_cnt;
        chk("idle_start_ready", start_ready, 1);
        start_valid      = 1'b1;
        start_thread_num = thr;
        step();
        start_valid = 1'b0;
        chk("load_start_ready", start_ready, 0);
        chk("load_rd_addr", mem_rd_thread_num, thr);
        chk("load_no_offer", eng_state_valid, 0);
        if (cl) begin
            clr_en         = 1'b1;
            clr_thread_num = thr;
        end
        step();
        clr_en = 1'b0;
        chk("offer_valid", eng_state_valid, 1);
        chk("offer_state", eng_state, exp);
        chk("offer_thr", eng_thread_num, thr);
        chk("offer_start_ready", start_ready, 0);
        eng_state_ready = 1'b1;
        step();
        eng_state_ready = 1'b0;
        chk("run_upd_ready", upd_ready, 1);
        chk("run_offer_drop", eng_state_valid, 0);
        for (int k = 0; k < rwait; k++) begin
            if (k == 0 && rc_en) begin
                clr_en         = 1'b1;
                clr_thread_num = rc_thr;
            end
            step();
            clr_en = 1'b0;
            chk("run_wait_ready", upd_ready, 1);
            chk("run_wait_start_ready", start_ready, 0);
        end
        upd_valid    = 1'b1;
        upd_state    = upd;
        upd_finished = fin;
        step();
        upd_valid    = 1'b0;
        upd_finished = 1'b0;
        chk("post_upd_ready", upd_ready, 0);
        if (!fin) begin
            chk("save_wr_en", mem_wr_en, 1);
            chk("save_wr_addr", mem_wr_thread_num, thr);
            chk("save_din", mem_din, upd);
            chk("save_start_ready", start_ready, 0);
            if (cs) begin
                clr_en         = 1'b1;
                clr_thread_num = thr;
            end
            step();
            clr_en = 1'b0;
        end
        chk("end_wr_en", mem_wr_en, 0);
        chk("end_start_ready", start_ready, 1);
        chk("write_count", wr_cnt - w0, fin ? 0 : 1);
    endtask

    typedef struct {
        logic [3:0]  thr;
        logic [18:0] upd;
        logic        fin;
        logic        cl;
        logic        cs;
        logic [18:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    logic [18:0] msaved [16];
    logic        mvalid [16];
    logic        merr;

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        RST              = 1'b1;
        start_valid      = 1'b0;
        start_thread_num = '0;
        clr_en           = 1'b0;
        clr_thread_num   = '0;
        eng_state_ready  = 1'b0;
        upd_valid        = 1'b0;
        upd_state        = '0;
        upd_finished     = 1'b0;

        tbl[0] = '{4'd3, W(128,5,0,0), 0, 0, 0, W(0,0,0,0),   0};
        tbl[1] = '{4'd3, W(256,0,0,1), 1, 0, 0, W(128,5,0,0), 0};
        tbl[2] = '{4'd3, W(10,1,0,0),  0, 0, 0, W(0,0,0,0),   0};
        tbl[3] = '{4'd7, W(50,2,1,0),  0, 0, 1, W(0,0,0,0),   0};
        tbl[4] = '{4'd7, W(60,0,0,0),  0, 0, 0, W(0,0,0,0),   0};
        tbl[5] = '{4'd3, W(11,1,0,0),  0, 1, 0, W(0,0,0,0),   0};
        tbl[6] = '{4'd9, W(200,0,0,0), 0, 0, 0, W(0,0,0,0),   0};
        tbl[7] = '{4'd9, W(100,3,0,0), 0, 0, 0, W(200,0,0,0), 1};
        tbl[8] = '{4'd7, W(61,0,0,0),  0, 0, 0, W(60,0,0,0),  1};

        #12;
        chk("rst_start_ready", start_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_eng_valid", eng_state_valid, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_eng_state", eng_state, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_din", mem_din, 0);
        RST = 1'b0;
        #1;
        chk("rel_start_ready", start_ready, 1);
        step();

        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].thr, tbl[i].upd, tbl[i].fin, tbl[i].cl,
                tbl[i].cs, tbl[i].exp, 0, 1'b0, 4'd0);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
        end
        chk("ram7_written", ram[7], W(61,0,0,0));

        step();
        chk("err_sticky", err, 1);
        RST = 1'b1;
        #2;
        RST = 1'b0;
        step();
        chk("err_cleared", err, 0);

        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        chk("stray_upd_err", err, 1);
        chk("stray_upd_idle", start_ready, 1);
        chk("stray_upd_nowr", mem_wr_en, 0);
        chk("stray_upd_noready", upd_ready, 0);
        step();
        chk("stray_upd_stays_idle", start_ready, 1);
        chk("stray_upd_nooffer", eng_state_valid, 0);
        RST = 1'b1;
        #2;
        RST = 1'b0;
        step();
        eng_state_ready = 1'b1;
        step();
        eng_state_ready = 1'b0;
        chk("stray_ready_err", err, 1);
        chk("stray_ready_idle", start_ready, 1);
        RST = 1'b1;
        #2;
        RST = 1'b0;
        step();

        txn(4'd5, W(40,1,0,0), 0, 0, 0, W(0,0,0,0), 0, 1'b0, 4'd0);
        start_valid      = 1'b1;
        start_thread_num = 4'd5;
        step();
        start_valid = 1'b0;
        step();
        chk("t5_restore", eng_state, W(40,1,0,0));
        eng_state_ready = 1'b1;
        step();
        eng_state_ready = 1'b0;
        chk("t5_run", upd_ready, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_start_ready", start_ready, 0);
        chk("arst_upd_ready", upd_ready, 0);
        chk("arst_wr_en", mem_wr_en, 0);
        begin
            int w0;
            w0 = wr_cnt;
            step();
            step();
            chk("arst_no_write", wr_cnt - w0, 0);
        end
        #2;
        RST = 1'b0;
        #1;
        chk("arst_rel_ready", start_ready, 1);
        txn(4'd5, W(1,0,0,0), 1, 0, 0, W(0,0,0,0), 0, 1'b0, 4'd0);
        chk("arst_ram_persist", ram[5], W(40,1,0,0));

        RST = 1'b1;
        #2;
        RST = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            msaved[i] = '0;
        end
        merr = 1'b0;

        for (int n = 0; n < 80; n++) begin
            logic [3:0]  thr;
            logic [3:0]  rc;
            logic        cl;
            logic        cs;
            logic        fin;
            logic        rce;
            int          rw;
            int          lt;
            int          nt;
            logic [18:0] exp;
            logic [18:0] upd;
            thr = ($urandom_range(0, 3) == 0) ?
                  4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cl  = ($urandom_range(0, 7) == 0);
            fin = ($urandom_range(0, 3) == 0);
            cs  = !fin && ($urandom_range(0, 5) == 0);
            rw  = $urandom_range(0, 3);
            rce = (rw > 0) && ($urandom_range(0, 3) == 0);
            rc  = 4'($urandom_range(0, 15));
            if (cl) mvalid[thr] = 1'b0;
            exp = mvalid[thr] ? msaved[thr] : '0;
            lt  = int'(exp[18:9]);
            if (lt > 0 && $urandom_range(0, 9) == 0)
                nt = $urandom_range(0, lt - 1);
            else
                nt = lt + $urandom_range(0, 150);
            if (nt > 1023) nt = 1023;
            upd = W(nt, $urandom_range(0, 127), $urandom_range(0, 1),
                    $urandom_range(0, 1));
            txn(thr, upd, fin, cl, cs, exp, rw, rce, rc);
            if (nt < lt) merr = 1'b1;
            if (rce) mvalid[rc] = 1'b0;
            if (fin) begin
                mvalid[thr] = 1'b0;
            end else begin
                msaved[thr] = upd;
                mvalid[thr] = !cs;
            end
            chk("rand_err", err, merr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/procb_state_ctrl.md
Name: procb_state_ctrl

Overview:
Per-thread save/restore controller for the process_bytes (procb) engine. It sits directly upstream of the per-thread saved-state RAM and drives that RAM's write port and its asynchronous read port. It also tracks which threads hold a valid saved record and loads that record into the engine when a thread is scheduled. When the engine finishes a block, the controller writes the updated record back, or discards it if the computation has finished.

Parameters:
N_THREADS, 16, number of threads sharing the engine
N_THREADS_MSB, `MSB(N_THREADS-1), thread index MSB

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
start_thread_num  in  N_THREADS_MSB+1  thread to schedule
start_valid  in  1  schedule request
start_ready  out  1  controller can accept a request (high only in IDLE)
clr_thread_num  in  N_THREADS_MSB+1  thread whose saved state is invalidated (new candidate assigned)
clr_en  in  1  invalidate strobe
eng_thread_num  out  N_THREADS_MSB+1  thread currently handed to the engine
eng_state  out  `PROCB_SAVE_MSB+1  restored state presented to the engine
eng_state_valid  out  1  eng_state is valid
eng_state_ready  in  1  engine accepts eng_state
upd_valid  in  1  engine returns an updated state
upd_state  in  `PROCB_SAVE_MSB+1  updated state
upd_finished  in  1  the SHA512 computation for this thread is complete
upd_ready  out  1  high only in RUN
mem_wr_thread_num  out  N_THREADS_MSB+1  RAM write address
mem_wr_en  out  1  RAM write enable
mem_din  out  `PROCB_SAVE_MSB+1  RAM write data
mem_rd_thread_num  out  N_THREADS_MSB+1  RAM read address
mem_dout  in  `PROCB_SAVE_MSB+1  RAM asynchronous read data
err  out  1  sticky protocol/consistency error

Behaviour:
- Save word layout, MSB first: total_bytes[9:0], rem_cnt[6:0], pad_pending, fin. `PROCB_SAVE_MSB = 18.
- Reset (asynchronous, RST high): state goes to IDLE; all valid bits are cleared; err=0; eng_state_valid=0; mem_wr_en=0; start_ready=0 while RST is high; all data outputs are 0.
- IDLE:
  - start_ready=1.
  - On start_valid, register start_thread_num into cur_thr and go to LOAD.
- LOAD (1 cycle):
  - mem_rd_thread_num=cur_thr.
  - eng_state is registered as mem_dout if valid[cur_thr], otherwise all-zero (fresh thread).
  - Go to OFFER.
- OFFER:
  - eng_state_valid=1.
  - When eng_state_ready is high, go to RUN on the next edge.
- RUN:
  - upd_ready=1.
  - On upd_valid:
    - if upd_finished=1: valid[cur_thr] is cleared and no RAM write occurs; go to IDLE.
    - otherwise: register upd_state and go to SAVE.
    - if upd_state.total_bytes < the loaded total_bytes: set err (wrap or regression); the write still proceeds.
- SAVE (1 cycle):
  - mem_wr_en=1, mem_wr_thread_num=cur_thr, mem_din=the registered state.
  - valid[cur_thr] is set.
  - Go to IDLE.
- Minimum turnaround: load-to-offer latency is 2 cycles from the accepted start. A new start is accepted no earlier than 1 cycle after SAVE, so the RAM read never sees a same-cycle write. No forwarding is needed.
- clr_en:
  - Clears valid[clr_thread_num] in any state.
  - Same cycle as SAVE on the same thread: clear wins, so the valid bit ends 0 even though the RAM is written.
  - Same cycle as LOAD on the same thread: the load sees the bit as already cleared and restores the zero state.
- err conditions (sticky until RST):
  - upd_valid outside RUN;
  - eng_state_ready outside OFFER;
  - start_valid with an out-of-range thread number (>= N_THREADS).
  - In each case the event is otherwise ignored.
- Reset mid-operation: the in-flight thread is abandoned and no write is issued. RAM contents persist, but every valid bit is 0.

Decomposition:
- sha512.vh holds `PROCB_SAVE_MSB and the field offset macros (PROCB_TOTAL_LSB, PROCB_REMCNT_LSB, PROCB_PAD_BIT, PROCB_FIN_BIT), plus the FSM state encodings.
- One natural sub-module: procb_valid_bits, the N_THREADS-wide flag register with set/clear ports and clear-priority. It is ~40 lines.
- The RAM itself stays a separate existing module, instantiated alongside this block.

Test Plan:
- Fresh thread: RST, then start thread 3 → eng_state=0 two cycles after acceptance; return upd total=128, rem=5 → one-cycle mem_wr_en to thread 3 with din {128,5,0,0}; valid[3]=1.
- Resume: start thread 3 again → mem_rd_thread_num=3 and eng_state equals the saved word; return total=256 with upd_finished=1 → no write and valid[3]=0; restarting thread 3 yields zero state.
- Clear race: during SAVE of thread 7, assert clr_en for thread 7 → RAM is written but valid[7]=0; next start of thread 7 yields zero state.
- Regression check: load total=200, return total=100 → err=1 and the write still occurs; err stays 1 until RST.
- Protocol: upd_valid pulsed in IDLE → err=1 and no state change; start_ready=0 in every non-IDLE cycle.
- Async reset in RUN for thread 5 (saved earlier) → no mem_wr_en; after release, thread 5 restores zero state and start_ready=1 on the first cycle after RST falls.
